// File: rtl/mem_bus_arbiter_pkg.sv
// Bus geometry shared by the memory arbiter, the system top and the I/O port logic.
package mem_bus_arbiter_pkg;

  localparam int BUS_ADDR_W = 16;
  localparam int BUS_DATA_W = 8;
  localparam logic [BUS_ADDR_W-1:0] BUS_IO_ADDR = 16'hBFFC;

  // Wide enough for any burst limit up to 15.
  localparam int BURST_CNT_W = 4;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one synchronous-read memory between the 6502 core and a DMA master,
// decodes the I/O port and bounds DMA bursts so the CPU always gets a cycle.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int                ADDR_W    = BUS_ADDR_W,
  parameter int                DATA_W    = BUS_DATA_W,
  parameter logic [ADDR_W-1:0] IO_ADDR   = BUS_IO_ADDR,
  parameter int                MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [ADDR_W-1:0] cpu_address_next,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_data_o,
  output logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_ready,
  input  logic              dma_req,
  input  logic              dma_write,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr_r,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_di,
  input  logic [DATA_W-1:0] mem_do,
  output logic              io_cs,
  input  logic [DATA_W-1:0] io_rdata
);

  logic                   own_dma;
  logic [BURST_CNT_W-1:0] burst_cnt;
  logic [ADDR_W-1:0]      dma_addr_q;
  logic [DATA_W-1:0]      dma_wdata_q;
  logic                   dma_write_q;
  logic                   nxt_dma;
  logic                   io_hit;

  assign nxt_dma = reset & dma_req & (burst_cnt < BURST_CNT_W'(MAX_BURST));
  assign dma_gnt = nxt_dma;

  // On the last stalled cycle the CPU's pending address is presented, so the
  // CPU cycle that follows a burst already has its read data.
  assign mem_addr_r = nxt_dma ? dma_addr : cpu_address_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      own_dma     <= 1'b0;
      burst_cnt   <= '0;
      dma_addr_q  <= '0;
      dma_wdata_q <= '0;
      dma_write_q <= 1'b0;
    end else begin
      own_dma   <= nxt_dma;
      burst_cnt <= nxt_dma ? burst_cnt + BURST_CNT_W'(1) : '0;
      if (nxt_dma) begin
        dma_addr_q  <= dma_addr;
        dma_wdata_q <= dma_wdata;
        dma_write_q <= dma_write;
      end
    end
  end

  // Reset qualifies the CPU-side strobes so nothing reaches memory or I/O while held.
  assign io_hit = reset & ~own_dma & (cpu_address == IO_ADDR);

  always_comb begin
    cpu_ready  = ~own_dma;
    io_cs      = io_hit;
    cpu_data_i = io_hit ? io_rdata : mem_do;
    dma_rdata  = mem_do;
    if (own_dma) begin
      mem_we     = dma_write_q;
      mem_addr_w = dma_addr_q;
      mem_di     = dma_wdata_q;
      dma_rvalid = ~dma_write_q;
    end else begin
      mem_we     = reset & cpu_write & ~io_hit;
      mem_addr_w = cpu_address;
      mem_di     = cpu_data_o;
      dma_rvalid = 1'b0;
    end
  end

endmodule
